se_frame_streamer: RTL and testbench

//  Transmit side of the SE block's input stream. Holds one feature-map frame written by the host.

---
 rtl/se_frame_streamer_pkg.sv | 25 ++
 rtl/se_frame_streamer_ram.sv | 51 +++++
 rtl/se_frame_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_se_frame_streamer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_frame_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : se_frame_streamer_pkg
// Purpose  : Shared types and default sizes for the SE input-stream transmit
//            path. The FSM state type and the frame geometry defaults are
//            kept here so the SE top and the streamer agree on them.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package se_frame_streamer_pkg;

  // Defaults shared with the SE top; FRAME_WORDS must match its input buffer.
  localparam int c_DEF_DATA_WIDTH  = 16;
  localparam int c_DEF_FRAME_WORDS = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KLOAD1 = 3'd1,
    S_KLOAD2 = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4
  } se_tx_state_t;

endpackage
`default_nettype wire

// File: rtl/se_frame_streamer_ram.sv
`default_nettype none
// ============================================================================
// Module   : se_frame_streamer_ram
// Purpose  : One-frame buffer, one write port and one read port, synchronous
//            read with one cycle of latency. The read register holds its value
//            when no read is issued, so the stream word stays stable on stalls.
// Ports    : clk, rst_n          clock, async active-low reset (read reg only)
//            i_we/i_waddr/i_wdata write port
//            i_re/i_raddr         read request and address
//            o_rdata              registered read data
// Revision : 1.0 - initial release
// ============================================================================
module se_frame_streamer_ram
  import se_frame_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int DEPTH      = c_DEF_FRAME_WORDS,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage is intentionally not reset; contents are undefined after reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/se_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : se_frame_streamer
// Purpose  : Transmit side of the SE input stream. Holds one host-written
//            frame, optionally pulses the conv1/conv2 kernel-load strobes,
//            streams the frame word by word, then counts returned SE beats
//            and reports frame completion or a drain timeout.
// Ports    : clk, rst_n                 clock, async active-low reset
//            i_wr_en/i_wr_addr/i_wr_data host frame write (IDLE only)
//            i_start, i_kload_req         start a frame, with kernel loads
//            i_pause                      stall: no read this cycle
//            i_se_out_valid               one per returned SE word
//            o_load_kernel_conv1/2        kernel-load strobes
//            o_in_data, o_input_valid     stream to SE top
//            o_busy, o_done, o_frame_count, o_error  status
// Revision : 1.0 - initial release
// ============================================================================
module se_frame_streamer
  import se_frame_streamer_pkg::*;
#(
  parameter int DATA_WIDTH    = c_DEF_DATA_WIDTH,
  parameter int FRAME_WORDS   = c_DEF_FRAME_WORDS,
  parameter int ADDR_W        = $clog2(FRAME_WORDS),
  parameter int KLOAD_CYCLES  = 1,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_start,
  input  logic                  i_kload_req,
  input  logic                  i_pause,
  input  logic                  i_se_out_valid,
  output logic                  o_load_kernel_conv1,
  output logic                  o_load_kernel_conv2,
  output logic [DATA_WIDTH-1:0] o_in_data,
  output logic                  o_input_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_frame_count,
  output logic                  o_error
);

  // Address/return counters carry one extra bit so FRAME_WORDS itself fits.
  localparam int c_CNT_W = ADDR_W + 1;
  localparam int c_KC_W  = $clog2(KLOAD_CYCLES + 1);
  localparam int c_TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_FRAME     = c_CNT_W'(FRAME_WORDS);
  localparam logic [c_CNT_W-1:0] c_LAST_ADDR = c_CNT_W'(FRAME_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_KC_W-1:0]  c_K_LAST    = c_KC_W'(KLOAD_CYCLES - 1);
  localparam logic [c_KC_W-1:0]  c_K_ONE     = c_KC_W'(1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE   = c_TMO_W'(1);

  se_tx_state_t        r_state;
  logic [c_KC_W-1:0]   r_kcnt;
  logic [c_CNT_W-1:0]  r_rd_addr;
  logic [c_CNT_W-1:0]  r_ret_cnt;
  logic [c_TMO_W-1:0]  r_tmo;
  logic                r_conv1;
  logic                r_conv2;
  logic                r_valid;
  logic                r_done;
  logic [15:0]         r_frame_count;
  logic                r_error;

  logic                w_busy;
  logic                w_rd_en;
  logic                w_ram_we;
  logic                w_count_ret;
  logic [c_CNT_W-1:0]  w_ret_next;

  assign w_busy   = (r_state != S_IDLE);
  assign w_rd_en  = (r_state == S_STREAM) && !i_pause;
  assign w_ram_we = i_wr_en && !w_busy;

  // Returned beats count outside IDLE; the done cycle itself and a full
  // counter do not count, so stray extra beats cannot wrap the counter.
  assign w_count_ret = i_se_out_valid && w_busy && !r_done && (r_ret_cnt != c_FRAME);
  assign w_ret_next  = r_ret_cnt + (w_count_ret ? c_CNT_ONE : '0);

  se_frame_streamer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_addr[ADDR_W-1:0]),
    .o_rdata (o_in_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_kcnt        <= '0;
      r_rd_addr     <= '0;
      r_ret_cnt     <= '0;
      r_tmo         <= '0;
      r_conv1       <= 1'b0;
      r_conv2       <= 1'b0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
      r_error       <= 1'b0;
    end else begin
      // Valid lines up with the RAM read register: one cycle after the read.
      r_valid   <= w_rd_en;
      r_ret_cnt <= w_ret_next;
      if (w_busy && (i_start || i_wr_en)) begin
        r_error <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rd_addr <= '0;
            r_ret_cnt <= '0;
            r_kcnt    <= '0;
            r_tmo     <= '0;
            if (i_kload_req) begin
              r_conv1 <= 1'b1;
              r_state <= S_KLOAD1;
            end else begin
              r_state <= S_STREAM;
            end
          end
        end

        S_KLOAD1: begin
          if (r_kcnt == c_K_LAST) begin
            r_kcnt  <= '0;
            r_conv1 <= 1'b0;
            r_conv2 <= 1'b1;
            r_state <= S_KLOAD2;
          end else begin
            r_kcnt <= r_kcnt + c_K_ONE;
          end
        end

        S_KLOAD2: begin
          if (r_kcnt == c_K_LAST) begin
            r_kcnt  <= '0;
            r_conv2 <= 1'b0;
            r_state <= S_STREAM;
          end else begin
            r_kcnt <= r_kcnt + c_K_ONE;
          end
        end

        S_STREAM: begin
          if (w_rd_en) begin
            r_rd_addr <= r_rd_addr + c_CNT_ONE;
            if (r_rd_addr == c_LAST_ADDR) begin
              r_tmo   <= '0;
              r_state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // done is raised while still in DRAIN, so a start in the done
          // cycle lands on a busy FSM and is rejected.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_ret_next == c_FRAME) begin
            r_done        <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_ret_cnt     <= '0;
            r_tmo         <= '0;
          end else if (i_se_out_valid) begin
            r_tmo <= '0;
          end else if (r_tmo == c_TMO_LAST) begin
            r_error   <= 1'b1;
            r_ret_cnt <= '0;
            r_tmo     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + c_TMO_ONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_load_kernel_conv1 = r_conv1;
  assign o_load_kernel_conv2 = r_conv2;
  assign o_input_valid       = r_valid;
  assign o_busy              = w_busy;
  assign o_done              = r_done;
  assign o_frame_count       = r_frame_count;
  assign o_error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_se_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_se_frame_streamer
// Purpose  : Directed self-checking bench for se_frame_streamer with the
//            default 1024-word frame, one-cycle kernel strobes and a
//            4096-cycle drain timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_se_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_wr_en;
  logic [9:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_start;
  logic        r_kload_req;
  logic        r_pause;
  logic        r_se_out_valid;
  logic        w_conv1;
  logic        w_conv2;
  logic [15:0] w_in_data;
  logic        w_valid;
  logic        w_busy;
  logic        w_done;
  logic [15:0] w_frame_count;
  logic        w_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  se_frame_streamer #(
    .DATA_WIDTH    (16),
    .FRAME_WORDS   (1024),
    .ADDR_W        (10),
    .KLOAD_CYCLES  (1),
    .DRAIN_TIMEOUT (4096)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_wr_en             (r_wr_en),
    .i_wr_addr           (r_wr_addr),
    .i_wr_data           (r_wr_data),
    .i_start             (r_start),
    .i_kload_req         (r_kload_req),
    .i_pause             (r_pause),
    .i_se_out_valid      (r_se_out_valid),
    .o_load_kernel_conv1 (w_conv1),
    .o_load_kernel_conv2 (w_conv2),
    .o_in_data           (w_in_data),
    .o_input_valid       (w_valid),
    .o_busy              (w_busy),
    .o_done              (w_done),
    .o_frame_count       (w_frame_count),
    .o_error             (w_error)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nbad;
    int beats;
    int gaps;
    int exp_d;
    int ndone;

    rst_n          = 1'b0;
    r_wr_en        = 1'b0;
    r_wr_addr      = '0;
    r_wr_data      = '0;
    r_start        = 1'b0;
    r_kload_req    = 1'b0;
    r_pause        = 1'b0;
    r_se_out_valid = 1'b0;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    chk("rst_conv1", w_conv1, 0);
    chk("rst_conv2", w_conv2, 0);
    chk("rst_valid", w_valid, 0);
    chk("rst_data", w_in_data, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_done", w_done, 0);
    chk("rst_fcount", w_frame_count, 0);
    chk("rst_error", w_error, 0);
    rst_n = 1'b1;
    cyc();

    // ---------------- frame 1: ramp, no kernel load ----------------
    // Address 0 first gets a junk value; the final write of 0 shares its
    // cycle with start and must win before the first read.
    for (int i = 0; i < 1024; i++) begin
      r_wr_en   = 1'b1;
      r_wr_addr = 10'(i);
      r_wr_data = (i == 0) ? 16'hDEAD : 16'(i);
      cyc();
    end
    r_wr_addr   = 10'd0;
    r_wr_data   = 16'd0;
    r_start     = 1'b1;
    r_kload_req = 1'b0;
    cyc();                               // cycle 1
    r_wr_en = 1'b0;
    r_start = 1'b0;
    chk("t1_busy_c1", w_busy, 1);
    chk("t1_valid_c1", w_valid, 0);
    chk("t1_error_c1", w_error, 0);
    nbad = 0;
    for (int c = 2; c <= 1025; c++) begin
      cyc();
      if (!(w_valid === 1'b1 && w_in_data === 16'(c - 2))) nbad++;
      if (w_conv1 !== 1'b0 || w_conv2 !== 1'b0) nbad++;
    end
    chk("t1_stream_beats", nbad, 0);
    cyc();                               // cycle 1026
    chk("t1_valid_after", w_valid, 0);
    chk("t1_busy_drain", w_busy, 1);

    // ---------------- return 1024 beats -> done ----------------
    r_se_out_valid = 1'b1;
    ndone = 0;
    for (int k = 0; k < 1023; k++) begin
      cyc();
      if (w_done !== 1'b0) ndone++;
    end
    cyc();
    r_se_out_valid = 1'b0;
    chk("t4_no_early_done", ndone, 0);
    chk("t4_done", w_done, 1);
    chk("t4_fcount", w_frame_count, 1);
    chk("t4_busy_in_done", w_busy, 1);
    cyc();
    chk("t4_done_pulse", w_done, 0);
    chk("t4_busy_idle", w_busy, 0);
    chk("t4_error", w_error, 0);

    // ---------------- frame 2: kernel load + pause ----------------
    r_kload_req = 1'b1;
    r_start     = 1'b1;
    cyc();                               // cycle 1
    r_start     = 1'b0;
    r_kload_req = 1'b0;
    chk("t2_conv1_c1", w_conv1, 1);
    chk("t2_conv2_c1", w_conv2, 0);
    cyc();                               // cycle 2
    chk("t2_conv1_c2", w_conv1, 0);
    chk("t2_conv2_c2", w_conv2, 1);
    cyc();                               // cycle 3
    chk("t2_conv2_c3", w_conv2, 0);
    chk("t2_valid_c3", w_valid, 0);
    cyc();                               // cycle 4
    chk("t2_valid_c4", w_valid, 1);
    chk("t2_data_c4", w_in_data, 0);
    beats = 1;
    gaps  = 0;
    nbad  = 0;
    exp_d = 1;
    for (int cur = 4; cur <= 1031; cur++) begin
      r_pause = (cur >= 100 && cur <= 104);
      cyc();
      if (w_valid === 1'b1) begin
        if (w_in_data !== 16'(exp_d)) nbad++;
        exp_d++;
        beats++;
      end else begin
        gaps++;
        if (w_in_data !== 16'(exp_d - 1)) nbad++;
      end
    end
    r_pause = 1'b0;
    chk("t3_beats", beats, 1024);
    chk("t3_gaps", gaps, 5);
    chk("t3_data_order", nbad, 0);
    cyc();                               // cycle 1033
    chk("t3_valid_end", w_valid, 0);
    chk("t3_data_hold", w_in_data, 16'd1023);

    // ---------------- short return -> drain timeout ----------------
    r_se_out_valid = 1'b1;
    ndone = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc();
      if (w_done !== 1'b0) ndone++;
    end
    r_se_out_valid = 1'b0;
    for (int k = 0; k < 4095; k++) begin
      cyc();
      if (w_done !== 1'b0 || w_error !== 1'b0 || w_busy !== 1'b1) ndone++;
    end
    chk("t5_before_timeout", ndone, 0);
    cyc();
    chk("t5_error", w_error, 1);
    chk("t5_busy", w_busy, 0);
    chk("t5_done", w_done, 0);
    chk("t5_fcount", w_frame_count, 1);

    // ---------------- start/write while busy, then reset mid-stream ----------------
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_error", w_error, 0);
    chk("t6_rst_fcount", w_frame_count, 0);
    rst_n = 1'b1;
    cyc();
    r_start = 1'b1;
    cyc();                               // cycle 1
    r_start = 1'b0;
    nbad = 0;
    for (int cur = 1; cur <= 29; cur++) begin
      if (cur == 10) begin
        r_start   = 1'b1;
        r_wr_en   = 1'b1;
        r_wr_addr = 10'd20;
        r_wr_data = 16'hBEEF;
      end else begin
        r_start = 1'b0;
        r_wr_en = 1'b0;
      end
      cyc();
      if (!(w_valid === 1'b1 && w_in_data === 16'(cur - 1))) nbad++;
    end
    r_start = 1'b0;
    r_wr_en = 1'b0;
    chk("t6_stream_intact", nbad, 0);
    chk("t6_error", w_error, 1);
    chk("t6_busy", w_busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", w_valid, 0);
    chk("t6_async_data", w_in_data, 0);
    chk("t6_async_busy", w_busy, 0);
    chk("t6_async_error", w_error, 0);
    cyc();
    chk("t6_edge_valid", w_valid, 0);
    chk("t6_edge_conv", {w_conv1, w_conv2}, 0);
    rst_n = 1'b1;
    cyc();
    chk("t6_idle_busy", w_busy, 0);
    chk("t6_idle_done", w_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
